image_cell_dispatcher: RTL and testbench

IMAGE_CELL_DISPATCHER -- requirements
Module: image_cell_dispatcher

---
 rtl/image_cell_dispatcher_pkg.sv | 27 ++
 rtl/image_cell_dispatcher_cell_pair_stage.sv | 44 ++++
 rtl/image_cell_dispatcher.sv | 162 ++++++++++++++++
 tb/tb_image_cell_dispatcher.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/image_cell_dispatcher_pkg.sv
// Shared types for the image cell dispatcher: pixel/operand types, FSM states
// and the pair payload carried by the output register.
package CellProcessingPkg;

  localparam int unsigned pixelDepth     = 8;
  localparam int unsigned opCodeWidth    = 4;
  localparam int unsigned userInputWidth = 16;

  typedef logic [pixelDepth-1:0]     pixel_t;
  typedef logic [userInputWidth-1:0] userInput_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dispatch_state_e;

  typedef struct packed {
    pixel_t cell_a;
    pixel_t cell_b;
    logic   sof;
    logic   eol;
    logic   eof;
  } cell_pair_t;

endpackage

// File: rtl/image_cell_dispatcher_cell_pair_stage.sv
// One-deep valid/ready output register holding a pixel pair and its frame tags.
module cell_pair_stage
  import CellProcessingPkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  cell_pair_t pair_i,
  input  logic       out_ready_i,
  output logic       out_valid_o,
  output cell_pair_t pair_o,
  output logic       slot_free_o
);

  logic       valid_q, valid_d;
  cell_pair_t pair_q, pair_d;

  // A load always wins; it is only issued when the slot is free or draining.
  always_comb begin
    valid_d = valid_q;
    pair_d  = pair_q;
    if (load_i) begin
      valid_d = 1'b1;
      pair_d  = pair_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      pair_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pair_q  <= pair_d;
    end
  end

  assign out_valid_o = valid_q;
  assign pair_o      = pair_q;
  assign slot_free_o = !valid_q || out_ready_i;

endmodule

// File: rtl/image_cell_dispatcher.sv
// Walks a width x height frame, pairing pixels from two source streams and
// emitting them with sof/eol/eof tags through a single output register.
module image_cell_dispatcher
  import CellProcessingPkg::*;
#(
  parameter int unsigned DIM_W = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [opCodeWidth-1:0] cfgOpcode,
  input  userInput_t             cfgUserInput,
  input  logic [DIM_W-1:0]       cfgWidth,
  input  logic [DIM_W-1:0]       cfgHeight,
  input  pixel_t                 srcA,
  input  pixel_t                 srcB,
  input  logic                   srcAValid,
  input  logic                   srcBValid,
  output logic                   srcAReady,
  output logic                   srcBReady,
  output pixel_t                 cellA,
  output pixel_t                 cellB,
  output userInput_t             userInputA,
  output logic [opCodeWidth-1:0] opcode,
  output logic                   cellValid,
  input  logic                   cellReady,
  output logic                   sof,
  output logic                   eol,
  output logic                   eof,
  output logic                   busy,
  output logic                   frameDone,
  output logic [DIM_W-1:0]       row,
  output logic [DIM_W-1:0]       col
);

  dispatch_state_e        state_q, state_d;
  logic [opCodeWidth-1:0] op_q, op_d;
  userInput_t             user_q, user_d;
  logic [DIM_W-1:0]       width_q, width_d;
  logic [DIM_W-1:0]       height_q, height_d;
  logic [DIM_W-1:0]       row_q, row_d;
  logic [DIM_W-1:0]       col_q, col_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic       slot_free;
  logic       accept;
  logic       last_col;
  logic       last_row;
  cell_pair_t pair_in;
  cell_pair_t pair_out;

  assign last_col = (col_q == width_q - DIM_W'(1));
  assign last_row = (row_q == height_q - DIM_W'(1));
  assign accept   = (state_q == RUN) && srcAValid && srcBValid && slot_free;

  // Tags are derived from the coordinate of the pair being accepted.
  assign pair_in.cell_a = srcA;
  assign pair_in.cell_b = srcB;
  assign pair_in.sof    = (row_q == '0) && (col_q == '0);
  assign pair_in.eol    = last_col;
  assign pair_in.eof    = last_col && last_row;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    user_d   = user_q;
    width_d  = width_q;
    height_d = height_q;
    row_d    = row_q;
    col_d    = col_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = cfgOpcode;
          user_d   = cfgUserInput;
          width_d  = cfgWidth;
          height_d = cfgHeight;
          row_d    = '0;
          col_d    = '0;
          state_d  = ((cfgWidth == '0) || (cfgHeight == '0)) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          if (last_col) begin
            col_d = '0;
            row_d = row_q + DIM_W'(1);
            if (last_row) begin
              state_d = DRAIN;
            end
          end else begin
            col_d = col_q + DIM_W'(1);
          end
        end
      end
      DRAIN: begin
        if (slot_free) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      user_q   <= '0;
      width_q  <= '0;
      height_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      user_q   <= user_d;
      width_q  <= width_d;
      height_q <= height_d;
      row_q    <= row_d;
      col_q    <= col_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  cell_pair_stage u_stage (
    .clk         (clk),
    .rst         (rst),
    .load_i      (accept),
    .pair_i      (pair_in),
    .out_ready_i (cellReady),
    .out_valid_o (cellValid),
    .pair_o      (pair_out),
    .slot_free_o (slot_free)
  );

  assign srcAReady  = accept;
  assign srcBReady  = accept;
  assign cellA      = pair_out.cell_a;
  assign cellB      = pair_out.cell_b;
  assign sof        = pair_out.sof;
  assign eol        = pair_out.eol;
  assign eof        = pair_out.eof;
  assign opcode     = op_q;
  assign userInputA = user_q;
  assign busy       = busy_q;
  assign frameDone  = done_q;
  assign row        = row_q;
  assign col        = col_q;

endmodule

// File: tb/tb_image_cell_dispatcher.sv
// Directed bench for image_cell_dispatcher: frame walk, stalls, config, reset.
module tb_image_cell_dispatcher;
  import CellProcessingPkg::*;

  localparam int unsigned DIM_W = 12;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   start = 1'b0;
  logic [opCodeWidth-1:0] cfgOpcode = '0;
  userInput_t             cfgUserInput = '0;
  logic [DIM_W-1:0]       cfgWidth = '0;
  logic [DIM_W-1:0]       cfgHeight = '0;
  pixel_t                 srcA = '0;
  pixel_t                 srcB = '0;
  logic                   srcAValid = 1'b0;
  logic                   srcBValid = 1'b0;
  logic                   srcAReady, srcBReady;
  pixel_t                 cellA, cellB;
  userInput_t             userInputA;
  logic [opCodeWidth-1:0] opcode;
  logic                   cellValid;
  logic                   cellReady = 1'b1;
  logic                   sof, eol, eof, busy, frameDone;
  logic [DIM_W-1:0]       row, col;

  int checks = 0;
  int errors = 0;

  image_cell_dispatcher #(.DIM_W(DIM_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfgOpcode(cfgOpcode), .cfgUserInput(cfgUserInput),
    .cfgWidth(cfgWidth), .cfgHeight(cfgHeight),
    .srcA(srcA), .srcB(srcB), .srcAValid(srcAValid), .srcBValid(srcBValid),
    .srcAReady(srcAReady), .srcBReady(srcBReady),
    .cellA(cellA), .cellB(cellB), .userInputA(userInputA), .opcode(opcode),
    .cellValid(cellValid), .cellReady(cellReady),
    .sof(sof), .eol(eol), .eof(eof),
    .busy(busy), .frameDone(frameDone), .row(row), .col(col)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [DIM_W-1:0] h, input logic [DIM_W-1:0] w,
                             input logic [opCodeWidth-1:0] op, input userInput_t ui);
    cfgHeight = h; cfgWidth = w; cfgOpcode = op; cfgUserInput = ui;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; srcAValid = 1'b1; srcBValid = 1'b1; cellReady = 1'b1;
    step(); step();
    checks++; if (cellValid !== 1'b0) begin errors++; $display("FAIL reset_cellValid got %b exp 0", cellValid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (frameDone !== 1'b0) begin errors++; $display("FAIL reset_frameDone got %b exp 0", frameDone); end
    checks++; if (row !== '0 || col !== '0) begin errors++; $display("FAIL reset_rowcol got %0d,%0d exp 0,0", row, col); end
    checks++; if (srcAReady !== 1'b0 || srcBReady !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b exp 00", srcAReady, srcBReady); end
    checks++; if (cellA !== '0 || cellB !== '0 || opcode !== '0 || userInputA !== '0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h exp 0", cellA, cellB, opcode, userInputA); end
    checks++; if ({sof, eol, eof} !== 3'b000) begin errors++; $display("FAIL reset_tags got %b exp 000", {sof, eol, eof}); end
    rst = 1'b1; srcAValid = 1'b0; srcBValid = 1'b0;
    step();
  endtask

  // 2 rows x 3 columns, sources always valid, sink always ready
  task automatic test_back_to_back();
    start_frame(12'd2, 12'd3, 4'hA, 16'hC0DE);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", busy); end
    checks++; if (opcode !== 4'hA || userInputA !== 16'hC0DE) begin
      errors++; $display("FAIL b2b_cfg got %h %h exp a c0de", opcode, userInputA); end
    for (int i = 0; i < 6; i++) begin
      srcA = pixel_t'(8'h10 + i); srcB = pixel_t'(8'h20 + i);
      srcAValid = 1'b1; srcBValid = 1'b1;
      #1;
      checks++; if (srcAReady !== 1'b1 || srcBReady !== 1'b1) begin
        errors++; $display("FAIL b2b_ready%0d got %b%b exp 11", i, srcAReady, srcBReady); end
      @(posedge clk); #1;
      checks++; if (cellValid !== 1'b1 || cellA !== pixel_t'(8'h10 + i) || cellB !== pixel_t'(8'h20 + i)) begin
        errors++; $display("FAIL b2b_pair%0d got v=%b %h %h exp v=1 %h %h", i, cellValid, cellA, cellB, 8'h10 + i, 8'h20 + i); end
      checks++; if ({sof, eol, eof} !== {i == 0, (i == 2) || (i == 5), i == 5}) begin
        errors++; $display("FAIL b2b_tags%0d got %b exp %b", i, {sof, eol, eof}, {i == 0, (i == 2) || (i == 5), i == 5}); end
      checks++; if (row !== DIM_W'((i + 1) / 3) || col !== DIM_W'((i + 1) % 3)) begin
        errors++; $display("FAIL b2b_coord%0d got %0d,%0d exp %0d,%0d", i, row, col, (i + 1) / 3, (i + 1) % 3); end
      checks++; if (frameDone !== 1'b0) begin errors++; $display("FAIL b2b_early_done%0d got %b exp 0", i, frameDone); end
    end
    srcA = 8'h99; srcB = 8'h99;
    #1;
    checks++; if (srcAReady !== 1'b0) begin errors++; $display("FAIL b2b_drain_ready got %b exp 0", srcAReady); end
    @(posedge clk); #1;
    checks++; if (frameDone !== 1'b1 || cellValid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_done got done=%b v=%b busy=%b exp 1 0 1", frameDone, cellValid, busy); end
    step();
    checks++; if (frameDone !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got done=%b busy=%b exp 0 0", frameDone, busy); end
    srcAValid = 1'b0; srcBValid = 1'b0;
  endtask

  task automatic test_src_stall();
    int n;
    start_frame(12'd1, 12'd2, 4'h1, 16'h0001);
    srcA = 8'h31; srcB = 8'h41; srcAValid = 1'b1; srcBValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (srcAReady !== 1'b0 || srcBReady !== 1'b0) begin
        errors++; $display("FAIL srcstall_ready%0d got %b%b exp 00", i, srcAReady, srcBReady); end
      @(posedge clk); #1;
      checks++; if (row !== '0 || col !== '0 || cellValid !== 1'b0) begin
        errors++; $display("FAIL srcstall_hold%0d got %0d,%0d v=%b exp 0,0 v=0", i, row, col, cellValid); end
    end
    srcBValid = 1'b1;
    #1;
    checks++; if (srcAReady !== 1'b1 || srcBReady !== 1'b1) begin
      errors++; $display("FAIL srcstall_release got %b%b exp 11", srcAReady, srcBReady); end
    @(posedge clk); #1;
    checks++; if (cellValid !== 1'b1 || cellA !== 8'h31 || cellB !== 8'h41 || col !== 12'd1) begin
      errors++; $display("FAIL srcstall_pair0 got v=%b %h %h col=%0d exp 1 31 41 1", cellValid, cellA, cellB, col); end
    srcA = 8'h32; srcB = 8'h42;
    step();
    checks++; if (cellA !== 8'h32 || {sof, eol, eof} !== 3'b011) begin
      errors++; $display("FAIL srcstall_pair1 got %h tags=%b exp 32 011", cellA, {sof, eol, eof}); end
    srcAValid = 1'b0; srcBValid = 1'b0;
    n = 0;
    while (frameDone !== 1'b1 && n < 8) begin step(); n++; end
    checks++; if (frameDone !== 1'b1) begin errors++; $display("FAIL srcstall_done_timeout got %b exp 1", frameDone); end
    step();
  endtask

  task automatic test_out_stall();
    int n;
    start_frame(12'd1, 12'd3, 4'h2, 16'h0002);
    srcA = 8'h51; srcB = 8'h61; srcAValid = 1'b1; srcBValid = 1'b1; cellReady = 1'b1;
    step();
    checks++; if (cellValid !== 1'b1 || cellA !== 8'h51) begin
      errors++; $display("FAIL outstall_pair0 got v=%b %h exp 1 51", cellValid, cellA); end
    cellReady = 1'b0; srcA = 8'h52; srcB = 8'h62;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (srcAReady !== 1'b0 || srcBReady !== 1'b0) begin
        errors++; $display("FAIL outstall_ready%0d got %b%b exp 00", i, srcAReady, srcBReady); end
      @(posedge clk); #1;
      checks++; if (cellValid !== 1'b1 || cellA !== 8'h51 || cellB !== 8'h61 || {sof, eol, eof} !== 3'b100 || col !== 12'd1) begin
        errors++; $display("FAIL outstall_hold%0d got v=%b %h %h tags=%b col=%0d exp 1 51 61 100 1",
                            i, cellValid, cellA, cellB, {sof, eol, eof}, col); end
    end
    cellReady = 1'b1;
    #1;
    checks++; if (srcAReady !== 1'b1) begin errors++; $display("FAIL outstall_release got %b exp 1", srcAReady); end
    @(posedge clk); #1;
    checks++; if (cellA !== 8'h52 || cellB !== 8'h62 || sof !== 1'b0 || col !== 12'd2) begin
      errors++; $display("FAIL outstall_pair1 got %h %h sof=%b col=%0d exp 52 62 0 2", cellA, cellB, sof, col); end
    srcA = 8'h53; srcB = 8'h63;
    step();
    checks++; if (cellA !== 8'h53 || {sof, eol, eof} !== 3'b011) begin
      errors++; $display("FAIL outstall_pair2 got %h tags=%b exp 53 011", cellA, {sof, eol, eof}); end
    srcAValid = 1'b0; srcBValid = 1'b0;
    n = 0;
    while (frameDone !== 1'b1 && n < 8) begin step(); n++; end
    checks++; if (frameDone !== 1'b1) begin errors++; $display("FAIL outstall_done_timeout got %b exp 1", frameDone); end
    step();
  endtask

  task automatic test_config();
    int n;
    cfgHeight = 12'd5; cfgWidth = 12'd0; cfgOpcode = 4'h7; cfgUserInput = 16'h7777;
    srcA = 8'h11; srcB = 8'h22; srcAValid = 1'b1; srcBValid = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (frameDone !== 1'b1 || busy !== 1'b1 || cellValid !== 1'b0 || srcAReady !== 1'b0) begin
      errors++; $display("FAIL zero_done got done=%b busy=%b v=%b rdy=%b exp 1 1 0 0", frameDone, busy, cellValid, srcAReady); end
    step();
    checks++; if (frameDone !== 1'b0 || busy !== 1'b0 || cellValid !== 1'b0) begin
      errors++; $display("FAIL zero_idle got done=%b busy=%b v=%b exp 0 0 0", frameDone, busy, cellValid); end
    srcAValid = 1'b0; srcBValid = 1'b0;
    start_frame(12'd1, 12'd2, 4'h3, 16'h1234);
    cfgOpcode = 4'h9; cfgUserInput = 16'hBEEF; cfgWidth = 12'd7; cfgHeight = 12'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (opcode !== 4'h3 || userInputA !== 16'h1234 || col !== '0 || busy !== 1'b1) begin
      errors++; $display("FAIL restart_ignored got %h %h col=%0d busy=%b exp 3 1234 0 1", opcode, userInputA, col, busy); end
    srcA = 8'hA0; srcB = 8'hB0; srcAValid = 1'b1; srcBValid = 1'b1;
    step();
    srcA = 8'hA1; srcB = 8'hB1;
    step();
    checks++; if (cellA !== 8'hA1 || {sof, eol, eof} !== 3'b011) begin
      errors++; $display("FAIL restart_width got %h tags=%b exp a1 011", cellA, {sof, eol, eof}); end
    srcAValid = 1'b0; srcBValid = 1'b0;
    n = 0;
    while (frameDone !== 1'b1 && n < 8) begin step(); n++; end
    checks++; if (frameDone !== 1'b1) begin errors++; $display("FAIL restart_done_timeout got %b exp 1", frameDone); end
    step();
  endtask

  task automatic test_reset_mid_frame();
    int done_seen;
    start_frame(12'd4, 12'd4, 4'h5, 16'h55AA);
    srcAValid = 1'b1; srcBValid = 1'b1; cellReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      srcA = pixel_t'(i + 1); srcB = pixel_t'(i + 8'h81);
      step();
    end
    srcA = 8'h04; srcB = 8'h84;
    rst = 1'b0;
    step();
    checks++; if (cellValid !== 1'b0 || busy !== 1'b0 || frameDone !== 1'b0 || srcAReady !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl got v=%b busy=%b done=%b rdy=%b exp 0 0 0 0", cellValid, busy, frameDone, srcAReady); end
    checks++; if (row !== '0 || col !== '0 || cellA !== '0 || cellB !== '0 || opcode !== '0 || userInputA !== '0) begin
      errors++; $display("FAIL midrst_data got %0d,%0d %h %h %h %h exp 0", row, col, cellA, cellB, opcode, userInputA); end
    checks++; if ({sof, eol, eof} !== 3'b000) begin errors++; $display("FAIL midrst_tags got %b exp 000", {sof, eol, eof}); end
    rst = 1'b1; srcAValid = 1'b0; srcBValid = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (frameDone === 1'b1 || cellValid === 1'b1) done_seen++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL midrst_quiet got %0d exp 0", done_seen); end
    start_frame(12'd1, 12'd1, 4'h6, 16'h0066);
    srcA = 8'h71; srcB = 8'h72; srcAValid = 1'b1; srcBValid = 1'b1;
    step();
    srcAValid = 1'b0; srcBValid = 1'b0;
    checks++; if (cellValid !== 1'b1 || cellA !== 8'h71 || cellB !== 8'h72 || {sof, eol, eof} !== 3'b111) begin
      errors++; $display("FAIL one_pixel got v=%b %h %h tags=%b exp 1 71 72 111", cellValid, cellA, cellB, {sof, eol, eof}); end
    step();
    checks++; if (frameDone !== 1'b1 || cellValid !== 1'b0) begin
      errors++; $display("FAIL one_pixel_done got done=%b v=%b exp 1 0", frameDone, cellValid); end
    step();
    checks++; if (frameDone !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL one_pixel_idle got done=%b busy=%b exp 0 0", frameDone, busy); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_src_stall();
    test_out_stall();
    test_config();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
